// File: rtl/sr_drive_pkg.sv
// Shared types for the SR flip-flop drive controller: FSM states and response codes.
package sr_drive_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_PULSE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_RESP  = 2'd3
  } state_t;

  typedef enum logic [1:0] {
    RSP_OK      = 2'd0,
    RSP_SKIP    = 2'd1,
    RSP_TIMEOUT = 2'd2,
    RSP_BADCH   = 2'd3
  } rsp_code_t;

endpackage

// File: rtl/sr_pulse_timer.sv
// Loadable saturating down-counter; o_done flags the enabled cycle on which it reaches 0.
module sr_pulse_timer #(
  parameter int MAX = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic i_load,
  input  logic i_en,
  output logic o_done
);

  localparam int W = (MAX < 1) ? 1 : $clog2(MAX + 1);

  logic [W-1:0] r_cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt <= '0;
    end else if (i_load) begin
      r_cnt <= W'(MAX);
    end else if (i_en && (r_cnt != '0)) begin
      r_cnt <= r_cnt - 1'b1;
    end
  end

  // Done on the last counted cycle so a load of N spans exactly N enabled cycles.
  assign o_done = i_en && (r_cnt <= W'(1));

endmodule

// File: rtl/sr_drive_ctrl.sv
// Drives S/R excitation for one channel per request, watches Q feedback, returns a coded response.
// Handshakes: a transfer happens on a rising clk edge where valid & ready are both high;
// rsp_valid is held with stable rsp_code/rsp_ch until that edge.
module sr_drive_ctrl
  import sr_drive_pkg::*;
#(
  parameter int CH          = 4,
  parameter int PULSE_CYC   = 2,
  parameter int TIMEOUT_CYC = 8,
  parameter int CHW         = (CH > 1) ? $clog2(CH) : 1
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           req_valid,
  output logic           req_ready,
  input  logic [CHW-1:0] req_ch,
  input  logic           req_val,
  output logic [CH-1:0]  s_out,
  output logic [CH-1:0]  r_out,
  input  logic [CH-1:0]  q_fb,
  output logic           rsp_valid,
  input  logic           rsp_ready,
  output logic [1:0]     rsp_code,
  output logic [CHW-1:0] rsp_ch,
  output logic [1:0]     dbg_state
);

  state_t            r_state;
  state_t            w_next;
  rsp_code_t         r_code;
  rsp_code_t         w_code_next;
  logic [CHW-1:0]    r_ch;
  logic              r_val;
  logic [CH-1:0]     r_s;
  logic [CH-1:0]     r_r;

  logic              w_accept;
  logic              w_bad;
  logic [(1<<CHW)-1:0] w_fb_ext;
  logic              w_fb_req;
  logic              w_fb_act;
  logic              w_pulse_done;
  logic              w_to_done;
  logic [CHW-1:0]    w_ch_sel;
  logic              w_val_sel;
  logic [CH-1:0]     w_onehot;

  assign w_accept = req_valid && (r_state == ST_IDLE);
  assign w_bad    = ({1'b0, req_ch} >= (CHW+1)'(CH));

  // Zero-extended feedback so an out-of-range channel index never reads past the bus.
  always_comb begin
    w_fb_ext = '0;
    w_fb_ext[CH-1:0] = q_fb;
  end

  assign w_fb_req = w_fb_ext[req_ch];
  assign w_fb_act = w_fb_ext[r_ch];

  sr_pulse_timer #(.MAX(PULSE_CYC)) u_pulse_timer (
    .clk    (clk),
    .rst    (rst),
    .i_load (w_accept && !w_bad && (w_fb_req != req_val)),
    .i_en   (r_state == ST_PULSE),
    .o_done (w_pulse_done)
  );

  sr_pulse_timer #(.MAX(TIMEOUT_CYC)) u_timeout_timer (
    .clk    (clk),
    .rst    (rst),
    .i_load ((r_state == ST_PULSE) && w_pulse_done),
    .i_en   (r_state == ST_WAIT),
    .o_done (w_to_done)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next      = r_state;
    w_code_next = r_code;
    case (r_state)
      ST_IDLE: begin
        if (w_accept) begin
          if (w_bad) begin
            w_next      = ST_RESP;
            w_code_next = RSP_BADCH;
          end else if (w_fb_req == req_val) begin
            w_next      = ST_RESP;
            w_code_next = RSP_SKIP;
          end else begin
            w_next = ST_PULSE;
          end
        end
      end
      ST_PULSE: begin
        if (w_pulse_done) w_next = ST_WAIT;
      end
      ST_WAIT: begin
        if (w_fb_act == r_val) begin
          w_next      = ST_RESP;
          w_code_next = RSP_OK;
        end else if (w_to_done) begin
          w_next      = ST_RESP;
          w_code_next = RSP_TIMEOUT;
        end
      end
      default: begin
        if (rsp_ready) w_next = ST_IDLE;
      end
    endcase
  end

  always_comb begin
    req_ready = (r_state == ST_IDLE);
    rsp_valid = (r_state == ST_RESP);
    rsp_code  = r_code;
    rsp_ch    = r_ch;
    s_out     = r_s;
    r_out     = r_r;
    dbg_state = r_state;
  end

  // Excitation is registered from next state so it is high exactly while the FSM is in PULSE.
  assign w_ch_sel  = w_accept ? req_ch  : r_ch;
  assign w_val_sel = w_accept ? req_val : r_val;
  assign w_onehot  = (w_next == ST_PULSE) ? (CH'(1) << w_ch_sel) : '0;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_ch   <= '0;
      r_val  <= 1'b0;
      r_code <= RSP_OK;
      r_s    <= '0;
      r_r    <= '0;
    end else begin
      if (w_accept) begin
        r_ch  <= req_ch;
        r_val <= req_val;
      end
      r_code <= w_code_next;
      r_s    <= w_val_sel  ? w_onehot : '0;
      r_r    <= !w_val_sel ? w_onehot : '0;
    end
  end

endmodule

// File: tb/tb_sr_drive_ctrl.sv
// Bench for sr_drive_ctrl: SR flip-flop bank model on the outputs, scoreboarded responses.
module tb_sr_drive_ctrl;

  localparam int CH = 4;
  localparam int P  = 2;
  localparam int TO = 8;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       req_valid = 1'b0;
  logic       req_ready;
  logic [1:0] req_ch = '0;
  logic       req_val = 1'b0;
  logic [3:0] s_out, r_out, q_fb;
  logic [3:0] q;
  logic [3:0] stuck = '0;
  logic       rsp_valid;
  logic       rsp_ready = 1'b1;
  logic [1:0] rsp_code, rsp_ch, dbg_state;

  logic       v3 = 1'b0;
  logic       rdy3;
  logic [1:0] ch3 = '0;
  logic       val3 = 1'b0;
  logic [2:0] s3, r3;
  logic [2:0] q3 = '0;
  logic       rv3;
  logic [1:0] code3, rch3, dbg3;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;
  int ready_mode = 0;
  int win_from = 1;
  int win_to = 0;
  logic [3:0] win_s = '0;
  logic [3:0] win_r = '0;
  logic [35:0] exp_q[$];

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, got timeout want completion");
    $fatal(1, "watchdog");
  end

  // SR flip-flop bank: set wins nothing, the DUT must never drive both.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) q <= '0;
    else     q <= (q | s_out) & ~r_out;
  end
  assign q_fb = q & ~stuck;

  always @(posedge clk) begin
    #1;
    case (ready_mode)
      0:       rsp_ready = 1'b1;
      1:       rsp_ready = ($urandom_range(0, 2) != 0);
      default: rsp_ready = 1'b0;
    endcase
  end

  sr_drive_ctrl #(.CH(CH), .PULSE_CYC(P), .TIMEOUT_CYC(TO)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
    .req_ch(req_ch), .req_val(req_val), .s_out(s_out), .r_out(r_out),
    .q_fb(q_fb), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_code(rsp_code), .rsp_ch(rsp_ch), .dbg_state(dbg_state)
  );

  sr_drive_ctrl #(.CH(3), .PULSE_CYC(P), .TIMEOUT_CYC(TO)) dut3 (
    .clk(clk), .rst(rst), .req_valid(v3), .req_ready(rdy3),
    .req_ch(ch3), .req_val(val3), .s_out(s3), .r_out(r3),
    .q_fb(q3), .rsp_valid(rv3), .rsp_ready(1'b1),
    .rsp_code(code3), .rsp_ch(rch3), .dbg_state(dbg3)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic send(input logic [1:0] ch, input logic v);
    int n;
    logic [1:0] code;
    int lat;
    n = 0;
    @(negedge clk);
    req_valid = 1'b1;
    req_ch    = ch;
    req_val   = v;
    while (!req_ready && n < 60) begin
      @(negedge clk);
      n++;
    end
    if (!req_ready) begin
      n_cmp++;
      n_bad++;
      $display("FAIL accept_timeout: got req_ready=0 want 1 within 60 cycles");
      req_valid = 1'b0;
      return;
    end
    // Expected outcome from the flip-flop bank as it stands at the accepting edge.
    if (q_fb[ch] == v) begin
      code = 2'd1;
      lat  = 1;
    end else if (v && stuck[ch]) begin
      code = 2'd2;
      lat  = P + TO + 1;
    end else begin
      code = 2'd0;
      lat  = P + 2;
    end
    exp_q.push_back({32'(cyc + lat), code, ch});
    if (code != 2'd1) begin
      win_from = cyc + 1;
      win_to   = cyc + P;
      win_s    = v ? (4'b0001 << ch) : 4'b0000;
      win_r    = v ? 4'b0000 : (4'b0001 << ch);
    end
    @(negedge clk);
    req_valid = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((exp_q.size() != 0 || !req_ready) && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (n >= 200) begin
      n_cmp++;
      n_bad++;
      $display("FAIL drain_timeout: got %0d pending want 0", exp_q.size());
    end
  endtask

  // ---------------- scoreboard monitor ----------------
  logic       prev_valid = 1'b0;
  logic       prev_ready = 1'b0;
  logic [1:0] hold_code = '0;
  logic [1:0] hold_ch = '0;

  always @(negedge clk) begin
    logic [35:0] e;
    logic [3:0]  es, er;
    if (rst) begin
      prev_valid = 1'b0;
      prev_ready = 1'b0;
    end else begin
      es = (cyc >= win_from && cyc <= win_to) ? win_s : 4'b0000;
      er = (cyc >= win_from && cyc <= win_to) ? win_r : 4'b0000;
      chk("s_out", 32'(s_out), 32'(es));
      chk("r_out", 32'(r_out), 32'(er));
      chk("sr_overlap", 32'(s_out & r_out), 32'd0);
      chk("exc_onehot", 32'($countones(s_out | r_out) <= 1), 32'd1);
      chk("ch3_exc_idle", 32'(s3 | r3), 32'd0);
      if (prev_valid && prev_ready) begin
        chk("rsp_one_cycle", 32'(rsp_valid), 32'd0);
        chk("ready_returns", 32'(req_ready), 32'd1);
      end else if (prev_valid) begin
        chk("rsp_held", 32'(rsp_valid), 32'd1);
        chk("code_stable", 32'(rsp_code), 32'(hold_code));
        chk("ch_stable", 32'(rsp_ch), 32'(hold_ch));
        chk("ready_low_in_resp", 32'(req_ready), 32'd0);
      end else if (rsp_valid) begin
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL unexpected_rsp: got code %0d ch %0d want no response", rsp_code, rsp_ch);
        end else begin
          e = exp_q.pop_front();
          chk("rsp_code", 32'(rsp_code), 32'(e[3:2]));
          chk("rsp_ch", 32'(rsp_ch), 32'(e[1:0]));
          chk("rsp_cycle", 32'(cyc), e[35:4]);
        end
      end
      prev_valid = rsp_valid;
      prev_ready = rsp_ready;
      hold_code  = rsp_code;
      hold_ch    = rsp_ch;
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    int n;
    repeat (3) @(negedge clk);
    chk("rst_req_ready", 32'(req_ready), 32'd1);
    chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rst_s_out", 32'(s_out), 32'd0);
    chk("rst_r_out", 32'(r_out), 32'd0);
    chk("rst_rsp_code", 32'(rsp_code), 32'd0);
    chk("rst_rsp_ch", 32'(rsp_ch), 32'd0);
    rst = 1'b0;

    send(2'd2, 1'b1);
    drain();
    send(2'd2, 1'b1);
    drain();
    stuck = 4'b0010;
    send(2'd1, 1'b1);
    drain();
    stuck = 4'b0000;

    // Response back-pressure: consumer stalls well past the response.
    ready_mode = 2;
    send(2'd2, 1'b0);
    n = 0;
    while (!rsp_valid && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("bp_rsp_seen", 32'(rsp_valid), 32'd1);
    repeat (5) @(negedge clk);
    ready_mode = 0;
    send(2'd3, 1'b1);
    drain();

    // Reset in the middle of a pulse.
    send(2'd0, 1'b1);
    chk("pulse_before_rst", 32'(s_out), 32'd1);
    rst = 1'b1;
    #1;
    chk("rst_async_s", 32'(s_out), 32'd0);
    chk("rst_async_r", 32'(r_out), 32'd0);
    exp_q.delete();
    win_from = 1;
    win_to   = 0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    #1;
    chk("post_rst_ready", 32'(req_ready), 32'd1);
    chk("post_rst_no_rsp", 32'(rsp_valid), 32'd0);
    repeat (15) @(negedge clk);

    // Randomized traffic with random stuck feedback and random consumer stalls.
    ready_mode = 1;
    for (int i = 0; i < 40; i++) begin
      drain();
      stuck = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 15)) : 4'b0000;
      send(2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)));
    end
    drain();
    ready_mode = 0;
    stuck = 4'b0000;

    // Three-channel build: out-of-range channel and a skip.
    @(negedge clk);
    v3 = 1'b1; ch3 = 2'd3; val3 = 1'b1;
    @(negedge clk);
    v3 = 1'b0;
    chk("badch_valid", 32'(rv3), 32'd1);
    chk("badch_code", 32'(code3), 32'd3);
    chk("badch_ch", 32'(rch3), 32'd3);
    @(negedge clk);
    chk("badch_done", 32'(rv3), 32'd0);
    chk("badch_ready", 32'(rdy3), 32'd1);
    v3 = 1'b1; ch3 = 2'd2; val3 = 1'b0;
    @(negedge clk);
    v3 = 1'b0;
    chk("ch3_skip_valid", 32'(rv3), 32'd1);
    chk("ch3_skip_code", 32'(code3), 32'd1);
    chk("ch3_skip_ch", 32'(rch3), 32'd2);
    repeat (3) @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
